// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// One shift-add or restoring shift-subtract step per cycle on operand
// magnitudes; signs are reapplied in a final FIX cycle. The result is {HI,LO}.
module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_next;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   mag_a, mag_b, a_raw;
  logic               sign_a, sign_b, dz_r;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] acc;

  logic               accept, in_signed, in_dz, in_early;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, fix_val;
  logic [WIDTH-1:0]   quo, rem;
  logic               fix_signed;

  // Decode the incoming request: magnitudes for signed ops and the divide-by-zero shortcut.
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE)) && !flush;
    in_signed = ~op[0];
    in_dz     = op[1] && (b == '0);
    in_early  = EARLY_ZERO && in_dz;
    abs_a     = (in_signed && a[WIDTH-1]) ? -a : a;
    abs_b     = (in_signed && b[WIDTH-1]) ? -b : b;
  end

  // One iteration step: acc = {partial product} for mult, {remainder, quotient} for div.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : '0)};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    if (div_diff[WIDTH])
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up: product sign sa^sb, quotient sign sa^sb, remainder follows the dividend.
  always_comb begin
    quo        = acc[WIDTH-1:0];
    rem        = acc[2*WIDTH-1:WIDTH];
    fix_signed = ~op_r[0];
    fix_val    = acc;
    if (op_r[1]) begin
      if (dz_r)
        fix_val = {a_raw, {WIDTH{1'b1}}};
      else
        fix_val = {((fix_signed && sign_a) ? -rem : rem),
                   ((fix_signed && (sign_a ^ sign_b)) ? -quo : quo)};
    end else if (fix_signed && (sign_a ^ sign_b)) begin
      fix_val = -acc;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status outputs; flush overrides everything but reset.
  always_comb begin
    state_next = state;
    busy       = (state == CALC) || (state == FIX);
    done       = (state == DONE);
    case (state)
      IDLE, DONE: state_next = start ? (in_early ? DONE : CALC) : IDLE;
      CALC:       if (counter == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: latch operands on accept, iterate in CALC, publish the result in FIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r        <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      a_raw       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz_r        <= 1'b0;
      counter     <= '0;
      acc         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_r        <= op;
      mag_a       <= abs_a;
      mag_b       <= abs_b;
      a_raw       <= a;
      sign_a      <= in_signed && a[WIDTH-1];
      sign_b      <= in_signed && b[WIDTH-1];
      dz_r        <= in_dz;
      counter     <= '0;
      acc         <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
      div_by_zero <= in_early;
      if (in_early) result <= {a, {WIDTH{1'b1}}};
    end else if (!flush && (state == CALC)) begin
      acc     <= op_r[1] ? div_next : mul_next;
      counter <= counter + 1'b1;
    end else if (!flush && (state == FIX)) begin
      result      <= fix_val;
      div_by_zero <= dz_r;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scoreboard queue fed by the driver,
// drained by a monitor on done, with a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [63:0] result;

  int          errors = 0;
  int          checks = 0;
  logic [64:0] exp_q[$];
  logic [63:0] lastRes;

  mult_div_unit #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Compare one value and log any discrepancy.
  task automatic checkOutput(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: returns {div_by_zero, HI, LO} from plain integer arithmetic.
  function automatic logic [64:0] refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o[1]) begin
      if (o[0]) r = {32'b0, x} * {32'b0, y};
      else      r = sx * sy;
      return {1'b0, r};
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    if (o[0]) return {1'b0, x % y, x / y};
    return {1'b0, 32'(sx % sy), 32'(sx / sy)};
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checkOutput("busy_with_done", {64'b0, busy}, 65'd0);
      if (exp_q.size() == 0)
        checkOutput("spurious_done", {64'b0, done}, 65'd0);
      else
        checkOutput("result", {div_by_zero, result}, exp_q.pop_front());
    end
  end

  // Issue one op in the cycle after the next edge, optionally poke start while busy,
  // and check latency and busy profile.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input int expLat, input bit interfere);
    int cyc;
    bit seen, busyOk;
    logic [64:0] e;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    e = refModel(o, x, y);
    exp_q.push_back(e);
    lastRes = e[63:0];
    cyc = 0; seen = 0; busyOk = 1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        if (busy !== (cyc != 0)) busyOk = 0;
        @(posedge clk); #1;
        cyc++;
        if (interfere && cyc == 5) begin
          start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput("timeout", {64'b0, seen}, 65'd1);
    checkOutput("latency", 65'(cyc), 65'(expLat));
    checkOutput("busy_profile", {64'b0, busyOk}, 65'd1);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] specials[5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    lastRes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {64'b0, busy}, 65'd0);
    checkOutput("reset_done", {64'b0, done}, 65'd0);
    checkOutput("reset_result", {1'b0, result}, 65'd0);
    checkOutput("reset_dbz", {64'b0, div_by_zero}, 65'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    checkOutput("multu_max", {1'b0, lastRes}, {1'b0, 64'hFFFF_FFFE_0000_0001});
    applyStimulus(2'b00, -32'sd3, 32'd7, 34, 0);
    applyStimulus(2'b00, -32'sd4, -32'sd5, 34, 0);
    applyStimulus(2'b10, -32'sd7, 32'd2, 34, 0);
    applyStimulus(2'b11, 32'd7, 32'd2, 34, 0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0);
    applyStimulus(2'b11, 32'd100, 32'd0, 1, 0);
    applyStimulus(2'b10, -32'sd9, 32'd0, 1, 0);
    applyStimulus(2'b00, 32'd12345, -32'sd678, 34, 1);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = pickOperand();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pickOperand();
      applyStimulus(ro, ra, rb, (ro[1] && rb == 32'd0) ? 1 : 34, (i % 5) == 0);
    end

    $display("[TB] flush during divide");
    @(posedge clk); #1;
    op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", {64'b0, busy}, 65'd0);
    checkOutput("flush_result", {1'b0, result}, {1'b0, lastRes});
    repeat (8) @(posedge clk);
    applyStimulus(2'b10, -32'sd1000, 32'd7, 34, 0);

    $display("[TB] reset during calculation");
    @(posedge clk); #1;
    op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_outputs", {busy, done, div_by_zero, result[61:0]}, 65'd0);
    checkOutput("midreset_result_hi", {63'b0, result[63:62]}, 65'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_reset", {63'b0, busy, done}, 65'd0);
    lastRes = '0;
    applyStimulus(2'b11, 32'd50, 32'd6, 34, 0);

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_empty", 65'(exp_q.size()), 65'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
